// File: rtl/cva6_spi_master_tx_pkg.sv
// Shared SPI definitions: TX state encoding, word geometry and the word-boundary
// masks used by both the transmit and receive halves of the SPI master.
package cva6_spi_master_tx_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    TRANSMIT  = 2'd1,
    WAIT_FIFO = 2'd2
  } tx_state_e;

  localparam int SPI_WORD_W     = 32;
  localparam int SPI_STD_SHIFT  = 1;
  localparam int SPI_QUAD_SHIFT = 4;

  // Counter LSB patterns marking the final step of a 32-bit word.
  localparam logic [4:0] SPI_STD_WORD_MASK  = 5'h1F;
  localparam logic [2:0] SPI_QUAD_WORD_MASK = 3'h7;

  function automatic logic spi_word_end(input logic quad, input logic [4:0] cnt_lsb);
    return quad ? (cnt_lsb[2:0] == SPI_QUAD_WORD_MASK) : (cnt_lsb == SPI_STD_WORD_MASK);
  endfunction

endpackage

// File: rtl/cva6_spi_master_tx.sv
// SPI master transmit datapath: pulls 32-bit FIFO words and shifts them out
// MSB-first on one lane (standard) or four lanes (quad), one step per tx_edge.
module cva6_spi_master_tx
  import cva6_spi_master_tx_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int RST_TRGT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             tx_edge,
  output logic             tx_done,
  output logic             sdo0,
  output logic             sdo1,
  output logic             sdo2,
  output logic             sdo3,
  input  logic             en_quad_in,
  input  logic [CNT_W-1:0] counter_in,
  input  logic             counter_in_upd,
  input  logic [31:0]      data,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             clk_en_o
);

  tx_state_e               state;
  logic [CNT_W-1:0]        counter;
  logic [CNT_W-1:0]        counter_trgt;
  logic [SPI_WORD_W-1:0]   sreg;
  logic [SPI_WORD_W-1:0]   sreg_shift;
  logic                    word_done;
  logic                    last;
  logic                    load;

  assign word_done  = spi_word_end(en_quad_in, counter[4:0]);
  // Target 0 wraps to all-ones here, giving a 2^CNT_W step transfer.
  assign last       = (counter == (counter_trgt - CNT_W'(1))) && tx_edge;
  assign tx_done    = last && (state == TRANSMIT);
  assign sreg_shift = en_quad_in ? (sreg << SPI_QUAD_SHIFT) : (sreg << SPI_STD_SHIFT);

  assign sdo0 = en_quad_in ? sreg[28] : sreg[31];
  assign sdo1 = en_quad_in & sreg[29];
  assign sdo2 = en_quad_in & sreg[30];
  assign sdo3 = en_quad_in & sreg[31];

  always_comb begin
    load     = 1'b0;
    clk_en_o = 1'b0;
    unique case (state)
      IDLE:      load = en && data_valid;
      TRANSMIT: begin
        clk_en_o = 1'b1;
        if (tx_edge && !last && word_done) begin
          if (data_valid) load     = 1'b1;
          else            clk_en_o = 1'b0;  // stop the SPI clock before the underrun
        end
      end
      WAIT_FIFO: load = data_valid;
      default:   load = 1'b0;
    endcase
  end

  assign data_ready = load;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      counter <= '0;
      sreg    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (load) begin
            sreg    <= data;
            counter <= '0;
            state   <= TRANSMIT;
          end
        end
        TRANSMIT: begin
          if (tx_edge) begin
            counter <= counter + CNT_W'(1);
            sreg    <= load ? data : sreg_shift;
            if (last) begin
              counter <= '0;
              state   <= IDLE;
            end else if (word_done && !data_valid) begin
              state <= WAIT_FIFO;
            end
          end
        end
        WAIT_FIFO: begin
          if (load) begin
            sreg  <= data;
            state <= TRANSMIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Length is programmed in bits; quad mode moves four bits per step.
  always_ff @(posedge clk) begin
    if (rst)                 counter_trgt <= CNT_W'(RST_TRGT);
    else if (counter_in_upd) counter_trgt <= en_quad_in ? (counter_in >> 2) : counter_in;
  end

endmodule

// File: tb/tb_cva6_spi_master_tx.sv
// Directed plus randomized bench for cva6_spi_master_tx; expected lane values
// are derived from the word list and the bit position of each strobe.
module tb_cva6_spi_master_tx;

  localparam int CNT_W = 16;

  logic             clk;
  logic             rst;
  logic             en;
  logic             tx_edge;
  logic             tx_done;
  logic             sdo0, sdo1, sdo2, sdo3;
  logic             en_quad_in;
  logic [CNT_W-1:0] counter_in;
  logic             counter_in_upd;
  logic [31:0]      data;
  logic             data_valid;
  logic             data_ready;
  logic             clk_en_o;

  int compared   = 0;
  int mismatched = 0;
  logic [31:0] wq[$];

  cva6_spi_master_tx #(.CNT_W(CNT_W), .RST_TRGT(8)) dut (
    .clk(clk), .rst(rst), .en(en), .tx_edge(tx_edge), .tx_done(tx_done),
    .sdo0(sdo0), .sdo1(sdo1), .sdo2(sdo2), .sdo3(sdo3),
    .en_quad_in(en_quad_in), .counter_in(counter_in), .counter_in_upd(counter_in_upd),
    .data(data), .data_valid(data_valid), .data_ready(data_ready), .clk_en_o(clk_en_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // Symbol k of the stream: bit (31-k%32) of word k/32, or nibble k%8 of word k/8.
  function automatic logic [3:0] exp_sym(input bit quad, input int k);
    int per, pos;
    logic [31:0] w, t;
    per = quad ? 8 : 32;
    pos = k % per;
    w   = wq[k / per];
    if (quad) begin
      t = w >> (28 - 4 * pos);
      return t[3:0];
    end
    t = w >> (31 - pos);
    return {3'b000, t[0]};
  endfunction

  task automatic present(input int wi, input int nwords, input int stall_word);
    data_valid = (wi < nwords) && (wi != stall_word);
    data       = (wi < nwords) ? wq[wi] : 32'h0;
  endtask

  task automatic xfer(input bit quad, input int len, input int gap, input bit upd,
                      input int stall_word, input int stall_cyc);
    int steps, per, nwords, wi, nready, bad;
    bit at_bound, exp_rdy;
    steps  = quad ? (len >> 2) : len;
    per    = quad ? 8 : 32;
    nwords = (steps + per - 1) / per;
    en_quad_in = quad;
    if (upd) begin
      counter_in     = CNT_W'(len);
      counter_in_upd = 1'b1;
      cyc();
      counter_in_upd = 1'b0;
    end
    en = 1'b1; data = wq[0]; data_valid = 1'b1;
    @(negedge clk);
    check("start_ready", data_ready, 1);
    check("start_clken", clk_en_o, 0);
    @(posedge clk); #1;
    en = 1'b0; wi = 1; nready = 1; bad = 0;
    present(wi, nwords, stall_word);
    for (int k = 0; k < steps; k++) begin
      for (int g = 1; g < gap; g++) begin
        @(negedge clk);
        if (clk_en_o !== 1'b1 || data_ready !== 1'b0 || tx_done !== 1'b0) bad++;
        @(posedge clk); #1;
      end
      tx_edge  = 1'b1;
      at_bound = ((k % per) == per - 1) && (k != steps - 1);
      exp_rdy  = at_bound && data_valid;
      @(negedge clk);
      check("sdo", {28'h0, sdo3, sdo2, sdo1, sdo0}, {28'h0, exp_sym(quad, k)});
      check("tx_done", tx_done, (k == steps - 1));
      check("ready", data_ready, exp_rdy);
      if (at_bound && !exp_rdy) check("stall_clken", clk_en_o, 0);
      if (data_ready === 1'b1 && k != 0 && at_bound) nready++;
      @(posedge clk); #1;
      tx_edge = 1'b0;
      if (exp_rdy) begin
        wi++;
        present(wi, nwords, stall_word);
      end else if (at_bound) begin
        for (int s = 0; s < stall_cyc; s++) begin
          tx_edge = 1'($urandom_range(0, 1));
          @(negedge clk);
          if (clk_en_o !== 1'b0 || data_ready !== 1'b0 || tx_done !== 1'b0 ||
              {sdo3, sdo2, sdo1, sdo0} !== 4'h0) bad++;
          @(posedge clk); #1;
        end
        tx_edge = 1'b0; data_valid = 1'b1; data = wq[wi];
        @(negedge clk);
        check("resume_ready", data_ready, 1);
        if (data_ready === 1'b1) nready++;
        @(posedge clk); #1;
        wi++;
        present(wi, nwords, stall_word);
        @(negedge clk);
        check("resume_clken", clk_en_o, 1);
        @(posedge clk); #1;
      end
    end
    data_valid = 1'b0;
    check("idle_glitches", bad, 0);
    check("ready_count", nready, nwords);
    @(negedge clk);
    check("end_clken", clk_en_o, 0);
    check("end_done", tx_done, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int bad, quad, len, steps, nw, sw;
    rst = 1'b1; en = 1'b0; tx_edge = 1'b0; en_quad_in = 1'b0;
    counter_in = '0; counter_in_upd = 1'b0; data = '0; data_valid = 1'b0;
    repeat (3) cyc();
    rst = 1'b0;
    @(negedge clk);
    check("rst_sdo", {28'h0, sdo3, sdo2, sdo1, sdo0}, 0);
    check("rst_done", tx_done, 0);
    check("rst_ready", data_ready, 0);
    check("rst_clken", clk_en_o, 0);
    @(posedge clk); #1;

    // Single mode, one byte of 0xA5.
    wq = '{32'hA500_0000};
    xfer(0, 8, 4, 1, -1, 0);

    // Quad mode, two pre-loaded words.
    wq = '{32'h1234_5678, 32'h9ABC_DEF0};
    xfer(1, 64, 2, 1, -1, 0);

    // Single mode, second word held back for 10 cycles.
    wq = '{$urandom, $urandom};
    xfer(0, 64, 2, 1, 1, 10);

    // Quad length 32 bits -> 8 steps.
    wq = '{$urandom};
    xfer(1, 32, 1, 1, -1, 0);

    // Reset mid-transfer, then a default-length transfer proves the target reset to 8.
    wq = '{32'hFFFF_FFFF, 32'hFFFF_FFFF};
    en_quad_in = 1'b0; counter_in = 16'd40; counter_in_upd = 1'b1; cyc(); counter_in_upd = 1'b0;
    en = 1'b1; data = wq[0]; data_valid = 1'b1; cyc();
    en = 1'b0; data_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tx_edge = 1'b1; cyc(); tx_edge = 1'b0; cyc();
    end
    rst = 1'b1; cyc(); rst = 1'b0;
    @(negedge clk);
    check("midrst_sdo", {28'h0, sdo3, sdo2, sdo1, sdo0}, 0);
    check("midrst_clken", clk_en_o, 0);
    check("midrst_ready", data_ready, 0);
    @(posedge clk); #1;
    tx_edge = 1'b1;
    @(negedge clk);
    check("midrst_done", tx_done, 0);
    @(posedge clk); #1;
    tx_edge = 1'b0;
    wq = '{$urandom};
    xfer(0, 8, 2, 0, -1, 0);

    // en with an empty FIFO must not start anything.
    en = 1'b1; data_valid = 1'b0; bad = 0;
    for (int c = 0; c < 6; c++) begin
      tx_edge = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (clk_en_o !== 1'b0 || data_ready !== 1'b0 || tx_done !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    en = 1'b0; tx_edge = 1'b0;
    check("en_no_valid", bad, 0);
    wq = '{$urandom};
    xfer(0, 16, 3, 1, -1, 0);

    // Randomized lengths, modes, strobe spacing and FIFO stalls.
    for (int it = 0; it < 8; it++) begin
      quad  = int'($urandom_range(0, 1));
      len   = quad ? int'($urandom_range(4, 160)) : int'($urandom_range(1, 100));
      steps = quad ? (len >> 2) : len;
      nw    = (steps + (quad ? 7 : 31)) / (quad ? 8 : 32);
      wq.delete();
      for (int w = 0; w < nw; w++) wq.push_back($urandom);
      sw = (nw > 1 && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, nw - 1)) : -1;
      xfer(quad[0], len, int'($urandom_range(1, 3)), 1, sw, int'($urandom_range(1, 6)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/cva6_spi_master_tx.md
Name: cva6_spi_master_tx

Overview:
- Transmit half of the SPI master datapath; counterpart of the SPI master receiver.
- Pulls 32-bit words from the TX FIFO over a valid/ready handshake and serialises them MSB-first on sdo0 (standard mode) or sdo3..sdo0 (quad mode), advancing one step per tx_edge strobe from the SPI clock generator.
- Tracks a programmable bit count, gates the SPI clock via clk_en_o while it has data, and pulses tx_done on the final bit.

Parameters:
- CNT_W, 16, width of counter_in, counter and counter target.
- RST_TRGT, 8, counter target value after reset.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- en  in  1  start request; sampled in IDLE.
- tx_edge  in  1  single-cycle shift strobe from the clock generator.
- tx_done  out  1  single-cycle pulse on the last shift of the transfer.
- sdo0  out  1  serial out; single-mode data, quad lane 0.
- sdo1  out  1  quad lane 1.
- sdo2  out  1  quad lane 2.
- sdo3  out  1  quad lane 3.
- en_quad_in  in  1  1 = quad mode (4 bits per tx_edge).
- counter_in  in  CNT_W  transfer length in bits.
- counter_in_upd  in  1  load strobe for counter_in.
- data  in  32  FIFO word.
- data_valid  in  1  FIFO word available.
- data_ready  out  1  word consumed this cycle (combinational).
- clk_en_o  out  1  SPI clock enable (combinational).

Behaviour:
- Reset (rst=1 at a clk edge):
  - Registers: state=IDLE, counter=0, counter_trgt=RST_TRGT, shift register=0.
  - Resulting outputs: sdo0..3=0, tx_done=0, data_ready=0, clk_en_o=0.
  - Reset mid-transfer aborts with no tx_done.
- Target register:
  - When counter_in_upd=1, counter_trgt <= en_quad_in ? counter_in>>2 : counter_in.
  - Otherwise counter_trgt holds.
  - The update applies in any state.
- Lane mapping:
  - Single mode: sdo0 = sreg[31], sdo1..3 = 0.
  - Quad mode: sdo3..sdo0 = sreg[31:28].
  - Outputs come directly from the register, so they are stable for the whole interval between strobes.
- word_done:
  - Single mode: counter[4:0]==31.
  - Quad mode: counter[2:0]==7.
- last: (counter == counter_trgt-1) && tx_edge; the arithmetic wraps modulo 2^CNT_W.
- tx_done = last && state==TRANSMIT.
- State IDLE:
  - clk_en_o=0.
  - If en && data_valid: data_ready=1, sreg<=data, counter<=0, go TRANSMIT.
  - If en && !data_valid: stay in IDLE; no request is latched.
- State TRANSMIT:
  - clk_en_o=1.
  - On tx_edge: counter++; sreg shifts left by 1 (single) or by 4 (quad), zero-filled.
  - If last: counter<=0, go IDLE. No data_ready, even if word_done is also true.
  - Else if word_done && data_valid: data_ready=1, sreg<=data (the reload overrides the shift), stay in TRANSMIT.
  - Else if word_done && !data_valid: clk_en_o=0 in that same cycle, go WAIT_FIFO.
  - With no tx_edge, everything holds.
- State WAIT_FIFO:
  - clk_en_o=0; sdo holds.
  - When data_valid: data_ready=1, sreg<=data, go TRANSMIT.
  - tx_edge is ignored in this state.
- Transfer-length boundaries:
  - A length that is not a multiple of 32 (single) or 8 (quad) ends mid-word; the unsent bits are discarded.
  - counter_trgt=0 means a transfer of 2^CNT_W steps.
- The block never drives data_ready outside the three load events above.

Decomposition:
- Shared SPI package holds:
  - the state enum tx_state_e {IDLE, TRANSMIT, WAIT_FIFO};
  - the constants SPI_WORD_W=32, SPI_STD_SHIFT=1, SPI_QUAD_SHIFT=4;
  - the word-boundary masks; the RX block uses the same ones.
- No sub-module; a single flat block is sufficient.

Test Plan:
- Single mode, counter_in=8, data=0xA5000000, en pulse, tx_edge every 4 clk:
  - sdo0 sequence is 1,0,1,0,0,1,0,1.
  - tx_done pulses once on the 8th strobe; clk_en_o falls; state returns to IDLE.
- Quad mode, counter_in=64, two words 0x12345678 and 0x9ABCDEF0 already valid:
  - sdo3..0 nibbles are 1..8, then 9..0.
  - data_ready pulses twice: at start and at the 8th strobe.
  - tx_done on the 16th strobe.
- Single mode, counter_in=64, second word withheld:
  - After the 32nd strobe, clk_en_o=0 and the block sits in WAIT_FIFO.
  - Assert data_valid 10 cycles later: data_ready=1 for one cycle, clk_en_o returns to 1, and the transfer completes correctly.
- counter_in_upd with en_quad_in=1 and counter_in=32:
  - counter_trgt becomes 8.
  - The transfer ends after 8 strobes, with a single data_ready.
- Assert rst after 5 strobes of a transfer:
  - Next cycle: IDLE, all outputs 0, counter_trgt=8, no tx_done.
- en=1 while data_valid=0 in IDLE:
  - The block stays in IDLE with clk_en_o=0 and data_ready=0.
  - Later en+data_valid starts the transfer normally.
